// File: rtl/apb_bfm_master_nslave.sv
// APB3 master engine: one request at a time, slave index decoded from ADDR[SEL_LSB+3:SEL_LSB].
// Latency: zero-wait transfer gives a response 3 cycles after accept, decode error 1 cycle.
// Backpressure: REQ_READY only in IDLE; the response is held until the RSP_READY handshake.
module apb_bfm_master_nslave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 16,
    parameter int SEL_LSB    = 24,
    parameter int TIMEOUT    = 256
) (
    input  logic                  SYSCLK,
    input  logic                  SYSRST,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WRITE,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ_WDATA,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [DATA_WIDTH-1:0] RSP_RDATA,
    output logic [1:0]            RSP_ERR,
    output logic [NUM_SLAVES-1:0] PSEL,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic                  PENABLE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    output logic [15:0]           XFER_CNT,
    output logic [15:0]           ERR_CNT
);

    localparam int            TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_SLV = 2'b01;
    localparam logic [1:0] ERR_DEC = 2'b10;
    localparam logic [1:0] ERR_TMO = 2'b11;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    req_idx;
    logic [3:0]    sel_idx;
    logic          dec_err;
    logic          req_hs;
    logic          rsp_hs;
    logic          tmo_hit;
    logic [TW-1:0] tmo_cnt;

    assign req_idx = REQ_ADDR[SEL_LSB+3:SEL_LSB];
    assign dec_err = int'({28'd0, req_idx}) >= NUM_SLAVES;
    assign req_hs  = REQ_VALID && REQ_READY;
    assign rsp_hs  = RSP_VALID && RSP_READY;
    // PREADY wins over the timeout on the terminal cycle.
    assign tmo_hit = (TIMEOUT != 0) && !PREADY && (tmo_cnt == TMO_LAST);

    always_ff @(posedge SYSCLK) begin
        if (SYSRST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_hs) state_nxt = dec_err ? RESP : SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (PREADY || tmo_hit) state_nxt = RESP;
            RESP:    if (RSP_READY) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        REQ_READY = (state == IDLE);
        RSP_VALID = (state == RESP);
        PENABLE   = (state == ACCESS);
        PSEL      = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            PSEL[i] = ((state == SETUP) || (state == ACCESS)) && (sel_idx == 4'(i));
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (SYSRST) begin
            sel_idx   <= '0;
            tmo_cnt   <= '0;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            RSP_RDATA <= '0;
            RSP_ERR   <= ERR_OK;
            XFER_CNT  <= '0;
            ERR_CNT   <= '0;
        end else begin
            if (req_hs) begin
                sel_idx <= req_idx;
                tmo_cnt <= '0;
                if (dec_err) begin
                    RSP_ERR   <= ERR_DEC;
                    RSP_RDATA <= '0;
                end else begin
                    // Bus fields only move for a real APB transfer; PWDATA only for writes.
                    PADDR  <= REQ_ADDR;
                    PWRITE <= REQ_WRITE;
                    if (REQ_WRITE) PWDATA <= REQ_WDATA;
                end
            end

            if (state == ACCESS) begin
                if (PREADY) begin
                    RSP_ERR   <= PSLVERR ? ERR_SLV : ERR_OK;
                    RSP_RDATA <= (!PWRITE && !PSLVERR) ? PRDATA : '0;
                end else if (tmo_hit) begin
                    RSP_ERR   <= ERR_TMO;
                    RSP_RDATA <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                end
            end

            if (rsp_hs) begin
                if (XFER_CNT != 16'hFFFF) XFER_CNT <= XFER_CNT + 16'd1;
                if ((RSP_ERR != ERR_OK) && (ERR_CNT != 16'hFFFF)) ERR_CNT <= ERR_CNT + 16'd1;
            end
        end
    end

endmodule
